// File: rtl/vreg_load_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vreg_load_sequencer: stalls decode and streams NUM_BEATS memory words into
// the weight or spike vector register.                        Revision: 1.0
// ---------------------------------------------------------------------------
module vreg_load_sequencer #(
  parameter int NUM_BEATS = 8,
  parameter int IDX_W     = 3,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [2:0]        id_funct3,
  input  logic [31:0]       base_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic              mem_req,
  output logic [31:0]       mem_addr,
  output logic              vr_we,
  output logic              vr_sel,
  output logic [IDX_W-1:0]  vr_idx,
  output logic [DATA_W-1:0] vr_wdata,
  output logic              busy,
  output logic              done
);

  localparam logic [6:0]       LOAD_OPCODE = 7'b0000010;
  localparam logic [IDX_W-1:0] LAST_BEAT   = IDX_W'(NUM_BEATS - 1);
  localparam logic [IDX_W-1:0] BEAT_ONE    = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [IDX_W-1:0] beat;
  logic [31:0]      base_q;
  logic             sel_q;
  logic             trigger;
  logic             beat_ack;

  assign trigger  = (state == IDLE) && id_valid && (id_opcode == LOAD_OPCODE);
  assign beat_ack = (state == REQ) && mem_ack;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat   <= '0;
      base_q <= '0;
      sel_q  <= 1'b0;
    end else begin
      state <= next_state;
      if (trigger) begin
        base_q <= base_addr;
        sel_q  <= (id_funct3 >= 3'd3);
        beat   <= '0;
      end else if (beat_ack) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + BEAT_ONE;
      end
    end
  end

  always_comb begin
    next_state = state;
    stall      = 1'b0;
    mem_req    = 1'b0;
    vr_we      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        stall = trigger;
        if (trigger) next_state = REQ;
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        vr_we   = mem_ack;
        if (mem_ack && (beat == LAST_BEAT)) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Address wraps modulo 2^32 by construction of the 32-bit add.
  assign mem_addr = base_q + {{(30 - IDX_W){1'b0}}, beat, 2'b00};
  assign vr_idx   = beat;
  assign vr_sel   = sel_q;
  assign vr_wdata = mem_rdata;
  assign busy     = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vreg_load_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_vreg_load_sequencer: directed scenarios plus randomized traffic checked
// against a transaction-level model.                         Revision: 1.0
// ---------------------------------------------------------------------------
module tb_vreg_load_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [6:0]  id_opcode = '0;
  logic [2:0]  id_funct3 = '0;
  logic [31:0] base_addr = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall, mem_req, vr_we, vr_sel, busy, done;
  logic [31:0] mem_addr, vr_wdata;
  logic [2:0]  vr_idx;

  vreg_load_sequencer #(.NUM_BEATS(8), .IDX_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .base_addr(base_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .stall(stall), .mem_req(mem_req), .mem_addr(mem_addr),
    .vr_we(vr_we), .vr_sel(vr_sel), .vr_idx(vr_idx), .vr_wdata(vr_wdata),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Model: a load is "in flight" with some number of words already written;
  // after the last word a single completion cycle follows.
  bit          m_inflight = 0;
  int          m_written  = 0;
  bit          m_finishing = 0;
  logic [31:0] m_base = '0;
  bit          m_svr = 0;

  bit s_stall, s_we, s_done;
  logic [31:0] req_addrs[$];
  int          wr_idx_log[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    bit          trig;
    logic [31:0] exp_addr;
    @(negedge clk);
    trig = !m_inflight && !m_finishing && id_valid && (id_opcode == 7'd2);
    exp_addr = m_base + 32'(m_written * 4);
    check_eq("stall",   {31'b0, stall},   {31'b0, trig | m_inflight});
    check_eq("busy",    {31'b0, busy},    {31'b0, m_inflight | m_finishing});
    check_eq("mem_req", {31'b0, mem_req}, {31'b0, m_inflight});
    check_eq("vr_we",   {31'b0, vr_we},   {31'b0, m_inflight & mem_ack});
    check_eq("done",    {31'b0, done},    {31'b0, m_finishing});
    check_eq("mem_addr", mem_addr, exp_addr);
    if (m_inflight && mem_ack) begin
      check_eq("vr_idx",   {29'b0, vr_idx}, 32'(m_written));
      check_eq("vr_sel",   {31'b0, vr_sel}, {31'b0, m_svr});
      check_eq("vr_wdata", vr_wdata, mem_rdata);
    end
    s_stall = stall; s_we = vr_we; s_done = done;
    if (mem_req) req_addrs.push_back(mem_addr);
    if (vr_we) wr_idx_log.push_back(int'(vr_idx));
    @(posedge clk);
    if (rst) begin
      m_inflight = 0; m_finishing = 0; m_written = 0; m_base = '0; m_svr = 0;
    end else if (m_finishing) begin
      m_finishing = 0;
    end else if (m_inflight) begin
      if (mem_ack) begin
        m_written++;
        if (m_written == 8) begin
          m_written = 0; m_inflight = 0; m_finishing = 1;
        end
      end
    end else if (trig) begin
      m_inflight = 1; m_written = 0; m_base = base_addr; m_svr = (id_funct3 >= 3);
    end
    #1;
  endtask

  // Issue one load; optionally stall the ack for wait_n cycles at beat wait_beat.
  task automatic load_seq(input logic [31:0] base, input logic [2:0] f3, input int wait_beat,
                          input int wait_n, input bit hold, output int stall_n, output int done_off);
    int acks = 0;
    int waited = 0;
    stall_n = 0; done_off = -1;
    id_valid = 1; id_opcode = 7'd2; id_funct3 = f3; base_addr = base; mem_ack = 0;
    for (int c = 0; c < 40 && done_off < 0; c++) begin
      if (c > 0) begin
        id_valid  = hold;
        mem_rdata = 32'hA0 + 32'(acks);
        if (acks == wait_beat && waited < wait_n) begin
          mem_ack = 0; waited++;
        end else mem_ack = 1;
      end
      step();
      if (s_stall) stall_n++;
      if (s_we) acks++;
      if (s_done) done_off = c;
    end
    id_valid = 0; mem_ack = 0;
  endtask

  initial begin
    int sn, dn, cnt;
    int idle_bad;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    step();

    // Idle with non-load opcodes.
    rst = 0; idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      id_valid = 1'($urandom); mem_ack = 1'($urandom);
      do id_opcode = 7'($urandom); while (id_opcode == 7'd2);
      step();
      if (s_stall || s_we || busy || mem_req) idle_bad++;
    end
    id_valid = 0;
    check_eq("idle_quiet", 32'(idle_bad), 32'd0);

    // WVR load, ack every cycle.
    req_addrs.delete(); wr_idx_log.delete();
    load_seq(32'h100, 3'd0, -1, 0, 0, sn, dn);
    check_eq("wvr_stall_cycles", 32'(sn), 32'd9);
    check_eq("wvr_done_offset", 32'(dn), 32'd9);
    check_eq("wvr_writes", 32'(wr_idx_log.size()), 32'd8);
    check_eq("wvr_last_addr", req_addrs[req_addrs.size()-1], 32'h11C);
    step();

    // SVR load with two wait cycles on beat 3.
    req_addrs.delete();
    load_seq(32'h2000, 3'd4, 3, 2, 0, sn, dn);
    check_eq("svr_done_offset", 32'(dn), 32'd11);
    check_eq("svr_stall_cycles", 32'(sn), 32'd11);
    cnt = 0;
    foreach (req_addrs[i]) if (req_addrs[i] == 32'h200C) cnt++;
    check_eq("svr_addr_hold", 32'(cnt), 32'd3);
    step();

    // Address wrap-around.
    req_addrs.delete();
    load_seq(32'hFFFF_FFF8, 3'd2, -1, 0, 0, sn, dn);
    check_eq("wrap_addr0", req_addrs[0], 32'hFFFF_FFF8);
    check_eq("wrap_addr2", req_addrs[2], 32'h0);
    check_eq("wrap_addr7", req_addrs[7], 32'h14);
    step();

    // Reset after the beat-2 write.
    id_valid = 1; id_opcode = 7'd2; id_funct3 = 3'd1; base_addr = 32'h400; mem_ack = 0;
    step();
    id_valid = 0; mem_ack = 1;
    repeat (3) step();
    rst = 1; mem_ack = 0;
    step();
    rst = 0; mem_ack = 1;
    step();
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_no_done", {31'b0, s_done}, 32'd0);
    mem_ack = 0;
    wr_idx_log.delete();
    load_seq(32'h500, 3'd7, -1, 0, 0, sn, dn);
    check_eq("post_rst_first_idx", 32'(wr_idx_log[0]), 32'd0);
    check_eq("post_rst_done", 32'(dn), 32'd9);
    step();

    // Load held valid through DONE, then a second load in the next (idle) cycle.
    load_seq(32'h600, 3'd0, -1, 0, 1, sn, dn);
    check_eq("held_stall_cycles", 32'(sn), 32'd9);
    load_seq(32'h700, 3'd3, -1, 0, 0, sn, dn);
    check_eq("second_done_offset", 32'(dn), 32'd9);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      id_valid  = 1'($urandom);
      id_opcode = ($urandom_range(0, 1) == 0) ? 7'd2 : 7'($urandom);
      id_funct3 = 3'($urandom);
      base_addr = $urandom;
      mem_ack   = ($urandom_range(0, 3) != 0);
      mem_rdata = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
